// File: rtl/sal_axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// ar_req_t uses the package widths; the top's ID_W/ADDR_W must match them.
package sal_axi_arb_pkg;

   localparam int MST_CNT   = 2;
   localparam int MST_IDX_W = 1;
   localparam int AR_ID_W   = 4;
   localparam int AR_ADDR_W = 32;
   localparam int AR_LEN_W  = 8;

   typedef struct packed {
      logic [AR_ID_W-1:0]   id;
      logic [AR_ADDR_W-1:0] addr;
      logic [AR_LEN_W-1:0]  len;
   } ar_req_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/sal_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner only when update is high.
module sal_rr_arb2
   import sal_axi_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [MST_CNT-1:0] req,
   input  logic               update,
   output logic [MST_CNT-1:0] gnt
);

   logic ptr_q;
   logic win;

   always_comb begin
      gnt = '0;
      win = ptr_q;
      case (req)
         2'b01: begin
            win = 1'b0;
            gnt = 2'b01;
         end
         2'b10: begin
            win = 1'b1;
            gnt = 2'b10;
         end
         2'b11: begin
            win = ptr_q;
            gnt = ptr_q ? 2'b10 : 2'b01;
         end
         default: begin
            win = ptr_q;
            gnt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (update) begin
         ptr_q <= ~win;
      end
   end

endmodule

// File: rtl/sal_axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin AR into one registered slot, R steered by the ID tag.
// Optional macro SAL_RD_ARB_OUTST_LIMIT_EN caps outstanding bursts per master at MAX_OUTST.
module sal_axi_rd_arbiter
   import sal_axi_arb_pkg::*;
#(
   parameter int ID_W      = AR_ID_W,
   parameter int ADDR_W    = AR_ADDR_W,
   parameter int DATA_W    = 128,
   parameter int MAX_OUTST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [7:0]        m0_arlen,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [7:0]        m1_arlen,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [ID_W-1:0]   m0_rid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [ID_W-1:0]   m1_rid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ID_W:0]     s_arid,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [7:0]        s_arlen,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [ID_W:0]     s_rid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast
);

   slot_state_t        state_q, state_d;
   ar_req_t            slot_q;
   logic               slot_idx_q;
   logic [MST_CNT-1:0] req, gnt, allow;
   logic               can_load, load, sel;

   if (MAX_OUTST < 1) begin : g_bad_max_outst
   end

   // A slot that is empty or draining this cycle can take the next winner.
   assign can_load   = (state_q == SLOT_EMPTY) || s_arready;
   assign req        = {m1_arvalid, m0_arvalid} & allow;
   assign load       = can_load && (gnt != '0);
   assign m0_arready = can_load && gnt[0];
   assign m1_arready = can_load && gnt[1];

   sal_rr_arb2 u_rr_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .update (load),
      .gnt    (gnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: if (load) state_d = SLOT_FULL;
         SLOT_FULL: begin
            if (load)           state_d = SLOT_FULL;
            else if (s_arready) state_d = SLOT_EMPTY;
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload only changes on a load, so it stays stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= '0;
         slot_idx_q <= 1'b0;
      end else if (load) begin
         slot_idx_q <= gnt[1];
         if (gnt[1]) begin
            slot_q <= '{id: m1_arid, addr: m1_araddr, len: m1_arlen};
         end else begin
            slot_q <= '{id: m0_arid, addr: m0_araddr, len: m0_arlen};
         end
      end
   end

   assign s_arvalid = (state_q == SLOT_FULL);
   assign s_arid    = {slot_idx_q, slot_q.id};
   assign s_araddr  = slot_q.addr;
   assign s_arlen   = slot_q.len;

   assign sel       = s_rid[ID_W];
   assign m0_rvalid = s_rvalid && !sel;
   assign m1_rvalid = s_rvalid && sel;
   assign s_rready  = sel ? m1_rready : m0_rready;
   assign m0_rid    = s_rid[ID_W-1:0];
   assign m1_rid    = s_rid[ID_W-1:0];
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m1_rresp  = s_rresp;
   assign m0_rlast  = s_rlast;
   assign m1_rlast  = s_rlast;

`ifdef SAL_RD_ARB_OUTST_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic r_done;
   assign r_done = s_rvalid && s_rready && s_rlast;

   for (genvar i = 0; i < MST_CNT; i++) begin : g_outst
      logic [CNT_W-1:0] cnt_q;
      logic             inc, dec, hit;

      assign hit      = r_done && (sel == 1'(i));
      assign inc      = load && gnt[i];
      assign dec      = hit && (cnt_q != '0);
      assign allow[i] = (cnt_q != CNT_W'(MAX_OUTST));

      // Accept and last beat in the same cycle cancel out.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (inc && !dec) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (dec && !inc) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            assert (!(hit && (cnt_q == '0)));
         end
      end
   end
`else
   assign allow = '1;
`endif

endmodule

// File: tb/tb_sal_axi_rd_arbiter.sv
// Directed bench for sal_axi_rd_arbiter; the outstanding-limit steps run only when SAL_RD_ARB_OUTST_LIMIT_EN is defined.
module tb_sal_axi_rd_arbiter;

   localparam int ID_W      = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 128;
   localparam int MAX_OUTST = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_arvalid, m0_arready, m1_arvalid, m1_arready;
   logic [ID_W-1:0]   m0_arid, m1_arid;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr;
   logic [7:0]        m0_arlen, m1_arlen;
   logic              m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
   logic [ID_W-1:0]   m0_rid, m1_rid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [1:0]        m0_rresp, m1_rresp;
   logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [ID_W:0]     s_arid, s_rid;
   logic [ADDR_W-1:0] s_araddr;
   logic [7:0]        s_arlen;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   sal_axi_rd_arbiter #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
      .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
   );

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change one unit after the edge; outputs are read a unit later.
   task automatic applyStimulus(input logic v0, input logic [ID_W-1:0] id0,
                                input logic [ADDR_W-1:0] a0, input logic [7:0] l0,
                                input logic v1, input logic [ID_W-1:0] id1,
                                input logic [ADDR_W-1:0] a1, input logic [7:0] l1,
                                input logic sar);
      m0_arvalid = v0; m0_arid = id0; m0_araddr = a0; m0_arlen = l0;
      m1_arvalid = v1; m1_arid = id1; m1_araddr = a1; m1_arlen = l1;
      s_arready  = sar;
      #1;
   endtask

   task automatic driveR(input logic v, input logic [ID_W:0] rid, input logic [DATA_W-1:0] d,
                         input logic [1:0] resp, input logic last, input logic rr0, input logic rr1);
      s_rvalid = v; s_rid = rid; s_rdata = d; s_rresp = resp; s_rlast = last;
      m0_rready = rr0; m1_rready = rr1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      driveR(0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      driveR(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("rst_arvalid", s_arvalid, 1'b0);
      checkOutput("rst_arid", s_arid, 5'h00);
      checkOutput("rst_araddr", s_araddr, 32'h0);
      checkOutput("rst_arlen", s_arlen, 8'h0);
      rst = 1'b0;

      // Single master request with 1-cycle AR latency
      applyStimulus(1, 4'h3, 32'h100, 8'd3, 0, 0, 0, 0, 1);
      checkOutput("single_m0_arready", m0_arready, 1'b1);
      checkOutput("single_m1_arready", m1_arready, 1'b0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("single_arvalid", s_arvalid, 1'b1);
      checkOutput("single_arid", s_arid, 5'h03);
      checkOutput("single_araddr", s_araddr, 32'h100);
      checkOutput("single_arlen", s_arlen, 8'd3);
      tick();
      checkOutput("single_drained", s_arvalid, 1'b0);

      for (int b = 0; b < 4; b++) begin
         driveR(1, 5'h03, DATA_W'(32'hD000 + b), 2'b00, (b == 3), 1, 0);
         checkOutput("r0_m0_rvalid", m0_rvalid, 1'b1);
         checkOutput("r0_m1_rvalid", m1_rvalid, 1'b0);
         checkOutput("r0_m0_rdata", m0_rdata, DATA_W'(32'hD000 + b));
         checkOutput("r0_m0_rid", m0_rid, 4'h3);
         checkOutput("r0_m0_rlast", m0_rlast, (b == 3) ? 1'b1 : 1'b0);
         checkOutput("r0_s_rready", s_rready, 1'b1);
         tick();
      end
      driveR(0, 0, 0, 0, 0, 0, 0);
      checkOutput("r0_idle", m0_rvalid, 1'b0);

      // R backpressure from m1 while m0_rready toggles
      for (int c = 0; c < 3; c++) begin
         driveR(1, 5'h1C, 128'hBEEF, 2'b10, 0, (c % 2 == 0) ? 1'b1 : 1'b0, 0);
         checkOutput("rbp_s_rready", s_rready, 1'b0);
         checkOutput("rbp_m1_rvalid", m1_rvalid, 1'b1);
         checkOutput("rbp_m0_rvalid", m0_rvalid, 1'b0);
         checkOutput("rbp_m1_rid", m1_rid, 4'hC);
         checkOutput("rbp_m1_rresp", m1_rresp, 2'b10);
         tick();
      end
      driveR(1, 5'h1C, 128'hBEEF, 2'b10, 0, 0, 1);
      checkOutput("rbp_release", s_rready, 1'b1);
      checkOutput("rbp_m1_rdata", m1_rdata, 128'hBEEF);
      tick();
      driveR(0, 0, 0, 0, 0, 0, 0);

      // Contention: alternating grants starting at master 0
      pulseReset();
      applyStimulus(1, 4'hA, 32'h200, 8'd1, 1, 4'h5, 32'h300, 8'd2, 1);
      for (int k = 0; k < 4; k++) begin
         checkOutput("rr_m0_arready", m0_arready, (k % 2 == 0) ? 1'b1 : 1'b0);
         checkOutput("rr_m1_arready", m1_arready, (k % 2 == 1) ? 1'b1 : 1'b0);
         tick();
         checkOutput("rr_arid", s_arid, (k % 2 == 0) ? 5'h0A : 5'h15);
         checkOutput("rr_araddr", s_araddr, (k % 2 == 0) ? 32'h200 : 32'h300);
      end

      // AR backpressure holds the slot; release hands the next grant to m1
      pulseReset();
      applyStimulus(1, 4'hA, 32'h200, 8'd1, 1, 4'h5, 32'h300, 8'd2, 0);
      checkOutput("bp_load_m0", m0_arready, 1'b1);
      checkOutput("bp_load_m1", m1_arready, 1'b0);
      tick();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1, 4'hA, 32'h240 + c, 8'd1, 1, 4'h5, 32'h300, 8'd2, 0);
         checkOutput("bp_arvalid", s_arvalid, 1'b1);
         checkOutput("bp_arid", s_arid, 5'h0A);
         checkOutput("bp_araddr", s_araddr, 32'h200);
         checkOutput("bp_m0_arready", m0_arready, 1'b0);
         checkOutput("bp_m1_arready", m1_arready, 1'b0);
         tick();
      end
      applyStimulus(1, 4'hA, 32'h240, 8'd1, 1, 4'h5, 32'h300, 8'd2, 1);
      checkOutput("bp_rel_m1_arready", m1_arready, 1'b1);
      checkOutput("bp_rel_m0_arready", m0_arready, 1'b0);
      tick();
      checkOutput("bp_rel_arid", s_arid, 5'h15);
      checkOutput("bp_rel_araddr", s_araddr, 32'h300);

      // Reset while FULL with the pointer at master 1
      applyStimulus(1, 4'h7, 32'h400, 8'd0, 0, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_arid_before", s_arid, 5'h07);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_arvalid", s_arvalid, 1'b0);
      checkOutput("mid_arid", s_arid, 5'h00);
      applyStimulus(1, 4'h2, 32'h500, 8'd0, 1, 4'h9, 32'h600, 8'd0, 1);
      checkOutput("mid_ptr_m0", m0_arready, 1'b1);
      checkOutput("mid_ptr_m1", m1_arready, 1'b0);
      tick();
      checkOutput("mid_arid_after", s_arid, 5'h02);

`ifdef SAL_RD_ARB_OUTST_LIMIT_EN
      // Outstanding limit of 2 on master 0
      pulseReset();
      applyStimulus(1, 4'h1, 32'h700, 8'd0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
         checkOutput("lim_m0_accept", m0_arready, 1'b1);
         tick();
      end
      checkOutput("lim_m0_masked", m0_arready, 1'b0);
      applyStimulus(1, 4'h1, 32'h700, 8'd0, 1, 4'h4, 32'h800, 8'd0, 1);
      checkOutput("lim_m1_served", m1_arready, 1'b1);
      tick();
      checkOutput("lim_m1_arid", s_arid, 5'h14);
      applyStimulus(1, 4'h1, 32'h700, 8'd0, 0, 0, 0, 0, 1);
      driveR(1, 5'h01, 0, 2'b00, 1, 1, 0);
      checkOutput("lim_still_masked", m0_arready, 1'b0);
      tick();
      driveR(0, 0, 0, 0, 0, 0, 0);
      checkOutput("lim_m0_unmasked", m0_arready, 1'b1);
      tick();
      checkOutput("lim_m0_third", s_arid, 5'h01);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
